// File: rtl/riscv_branch_pkg.sv
// riscv_branch_pkg: shared XLEN default, branch funct3 encodings and condition flag indices
package riscv_branch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NCOND = 6;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [2:0] {C_BLT, C_BGE, C_BLTU, C_BGEU, C_BEQ, C_BNE} cond_e;
  localparam int FI_BLT = 5;
  localparam int FI_BGE = 4;
  localparam int FI_BLTU = 3;
  localparam int FI_BGEU = 2;
  localparam int FI_BEQ = 1;
  localparam int FI_BNE = 0;
  function automatic logic multi_hot(input logic [NCOND-1:0] f);
    return |(f & (f - {{(NCOND-1){1'b0}}, 1'b1}));
  endfunction
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational condition evaluation of operands against the one-hot branch flags
module branch_cmp
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [NCOND-1:0] flags,
  output logic             taken_raw,
  output logic             onehot_err
);
  logic lt, ltu, eq;
  assign lt = $signed(rs1) < $signed(rs2);
  assign ltu = rs1 < rs2;
  assign eq = rs1 == rs2;
  assign onehot_err = multi_hot(flags);
  assign taken_raw = !onehot_err && (
    (flags[FI_BLT] && lt) || (flags[FI_BGE] && !lt) ||
    (flags[FI_BLTU] && ltu) || (flags[FI_BGEU] && !ltu) ||
    (flags[FI_BEQ] && eq) || (flags[FI_BNE] && !eq));
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: registered branch resolution with valid/ready handshake and statistics.
// BRANCH_PREDICT_EN adds pred_taken/mispredict and redirects on mispredict instead of taken.
module branch_resolver
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
`ifdef BRANCH_PREDICT_EN
  input  logic            pred_taken,
  output logic            mispredict,
`endif
  input  logic            branch_lsr,
  input  logic            branch_grtr,
  input  logic            branch_lsrU,
  input  logic            branch_grtrU,
  input  logic            branch_eql,
  input  logic            branch_neql,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            flush,
  output logic            onehot_err,
  output logic            misalign_err,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
);
  logic [NCOND-1:0] flags;
  logic [XLEN-1:0] target, seq_pc;
  logic accept, taken_raw, oh_d, one_d, mis_d, taken_d, redirect;
  assign flags = {branch_lsr, branch_grtr, branch_lsrU, branch_grtrU, branch_eql, branch_neql};
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1(rs1_data),
    .rs2(rs2_data),
    .flags(flags),
    .taken_raw(taken_raw),
    .onehot_err(oh_d)
  );
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign target = pc + imm;
  assign seq_pc = pc + XLEN'(4);
  assign one_d = |flags && !oh_d;
  // a misaligned target suppresses the redirect and falls through
  assign mis_d = taken_raw && |target[1:0];
  assign taken_d = taken_raw && !mis_d;
`ifdef BRANCH_PREDICT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mispredict <= 1'b0;
    else if (accept) mispredict <= taken_d ^ pred_taken;
  assign redirect = mispredict;
`else
  assign redirect = taken;
`endif
  // only the retire cycle redirects, so a stalled result cannot repeat the pulse
  assign flush = out_valid && out_ready && redirect;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      taken <= 1'b0;
      next_pc <= '0;
      onehot_err <= 1'b0;
      misalign_err <= 1'b0;
      br_count <= '0;
      taken_count <= '0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      if (accept) begin
        taken <= taken_d;
        next_pc <= taken_d ? target : seq_pc;
        onehot_err <= oh_d;
        misalign_err <= mis_d;
      end
      if (accept && one_d) br_count <= br_count + 32'd1;
      if (accept && taken_d) taken_count <= taken_count + 32'd1;
    end
  end
endmodule
